booth_mul_arbiter: RTL and testbench
====================================

Name: booth_mul_arbiter

Overview:
Shares one combinational 4x4 signed booth_multiplier between NREQ requesters.
- Round-robin arbitration over valid/ready request channels.
- Operands of the granted request feed the multiplier; the product is registered with the requester ID onto one valid/ready result channel.
- Sits between client blocks and the single multiplier instance; sustains one product per cycle when unstalled.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ
CNTW, 16, width of completed-operation counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request valid, bit i = requester i
req_ready  out  NREQ  one-hot grant/accept, bit i = requester i
req_x  in  4*NREQ  multiplicand, slice [4i+3:4i] = requester i, two's complement
req_y  in  4*NREQ  multiplier, same packing
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_z  out  8  signed product X*Y
res_id  out  IDW  index of requester that issued the product
op_count  out  CNTW  number of results consumed (res_valid & res_ready)

Behaviour:
- One clock domain: clk. Reset asynchronous, active-low on rst_n.
- Reset values: res_valid=0, res_z=0, res_id=0, op_count=0, rr pointer=0. req_ready=0 while rst_n=0.
- slot_free = !res_valid | res_ready.
- Arbitration (combinational):
  - When slot_free, grant the first asserted req_valid bit searching from index ptr upward, wrapping at NREQ-1 -> 0.
  - req_ready = one-hot grant; all zero when !slot_free or no request.
  - req_ready never depends on req_x/req_y.
- Accept: handshake when req_valid[i] & req_ready[i].
  - Next edge: res_z <= booth product of slice i; res_id <= i; res_valid <= 1.
  - ptr <= (i+1) mod NREQ.
- Latency: result visible exactly 1 cycle after accept.
- Result channel:
  - res_valid & !res_ready -> res_z and res_id held stable; no grants issued.
  - res_valid & res_ready with no new accept -> res_valid <= 0 next edge; res_z/res_id keep their old values.
  - Simultaneous consume and accept -> res_valid stays 1, new data loaded (back-to-back, no bubble).
- Pointer: advances only on accept; unchanged when idle or stalled.
- op_count: increments on each res_valid & res_ready; wraps modulo 2**CNTW.
- Arithmetic: X, Y are signed 4-bit. Z is the full 8-bit signed product; range -56..64, never overflows.
- Requester protocol: a requester holds req_valid and operands until accepted. A request dropped before accept is simply not served; no error.
- Reset mid-operation:
  - Pending result discarded; res_valid=0 immediately (async).
  - ptr=0; op_count=0.
  - After deassertion, first grant goes to the lowest-index valid requester.
- FSM view (2 states, encoded as res_valid):
  - EMPTY -> FULL on accept.
  - FULL -> FULL on consume+accept, or on stall.
  - FULL -> EMPTY on consume with no accept.

Decomposition:
- Shared package: operand width constant (4), product width constant (8), signed-range constants for checkers.
- One sub-module: booth_multiplier (existing, ports X, Y, Z), instantiated once, fed by a mux of granted operands.
- Round-robin grant logic stays inline.

Test Plan:
- Single op: req 0, x=3, y=5, res_ready=1 -> req_ready[0]=1 same cycle; next cycle res_valid=1, res_z=8'h0F, res_id=0; op_count=1.
- Signed corners: x=4'h8, y=4'h8 -> 8'h40; x=7, y=4'hF -> 8'hF9; x=0, y=4'h9 -> 8'h00.
- Fairness: all 4 requesters valid continuously, res_ready=1 -> grant order 0,1,2,3,0,1; one result per cycle; op_count=6 after 6 handshakes.
- Backpressure: result pending, res_ready=0 for 5 cycles -> req_ready=0, res_z/res_id stable; res_ready=1 -> consume and next grant in the same cycle.
- Reset mid-stream: rst_n low while res_valid=1 -> res_valid, op_count, ptr cleared asynchronously; after release with req 2 and req 3 valid -> req 2 granted first.
- Exhaustive sweep: every x, y in 0..15 from random requesters with random res_ready stalls -> every res_z equals the signed product, and res_id matches the issuer.

Source files
------------

// File: rtl/booth_mul_arbiter_pkg.sv
// Shared widths and checker constants for the arbitrated 4x4 signed Booth multiplier.
package booth_mul_arbiter_pkg;
  localparam int OPW      = 4;
  localparam int PRODW    = 8;
  localparam int PROD_MIN = -56;
  localparam int PROD_MAX = 64;

  typedef logic [OPW-1:0]   opnd_t;
  typedef logic [PRODW-1:0] prod_t;
endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Request and result channels between client blocks and the multiplier arbiter.
interface booth_mul_arbiter_if
  import booth_mul_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][OPW-1:0] req_x;
  logic [NREQ-1:0][OPW-1:0] req_y;
  logic                    res_valid;
  logic                    res_ready;
  prod_t                   res_z;
  logic [IDW-1:0]          res_id;

  modport master (
    output req_valid, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_z, res_id
  );

  modport slave (
    input  req_valid, req_x, req_y, res_ready,
    output req_ready, res_valid, res_z, res_id
  );
endinterface

// File: rtl/booth_multiplier.sv
// Combinational radix-4 Booth multiplier: full-width signed product of two OPW-bit operands.
module booth_multiplier
  import booth_mul_arbiter_pkg::*;
(
  input  opnd_t X,
  input  opnd_t Y,
  output prod_t Z
);
  prod_t          xe;
  logic [OPW:0]   ye;

  assign xe = {{(PRODW-OPW){X[OPW-1]}}, X};
  assign ye = {Y, 1'b0};

  // Each 3-bit overlapping window of Y selects one of 0, +-X, +-2X.
  function automatic prod_t booth_pp(input logic [2:0] w, input prod_t m);
    case (w)
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m << 1;
      3'b100:         booth_pp = -(m << 1);
      3'b101, 3'b110: booth_pp = -m;
      default:        booth_pp = '0;
    endcase
  endfunction

  always_comb begin
    Z = '0;
    for (int i = 0; i < OPW/2; i++)
      Z = Z + (booth_pp(ye[2*i +: 3], xe) << (2*i));
  end
endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among NREQ requesters,
// with a single registered result slot that streams one product per cycle.
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
)(
  input  logic            clk,
  input  logic            rst_n,
  booth_mul_arbiter_if.slave bus,
  output logic [CNTW-1:0] op_count
);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state;
  logic [IDW-1:0]  ptr, gnt_idx, res_id_q;
  logic [NREQ-1:0] gnt;
  logic            found, slot_free, accept;
  int              idx;
  opnd_t           mul_x, mul_y;
  prod_t           mul_z, res_z_q;

  assign bus.res_valid = (state == ST_FULL);
  assign bus.res_z     = res_z_q;
  assign bus.res_id    = res_id_q;
  assign slot_free     = !bus.res_valid || bus.res_ready;

  // First valid requester at or after ptr, wrapping; independent of operands.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  assign accept = rst_n && slot_free && found;

  always_comb begin
    gnt = '0;
    if (accept) gnt[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = gnt;
  assign mul_x = bus.req_x[gnt_idx];
  assign mul_y = bus.req_y[gnt_idx];

  booth_multiplier u_mul (
    .X (mul_x),
    .Y (mul_y),
    .Z (mul_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      res_z_q  <= '0;
      res_id_q <= '0;
      ptr      <= '0;
      op_count <= '0;
    end else begin
      if (bus.res_valid && bus.res_ready) op_count <= op_count + CNTW'(1);
      // Accept wins over consume so the slot refills with no bubble.
      if (accept) begin
        state    <= ST_FULL;
        res_z_q  <= mul_z;
        res_id_q <= gnt_idx;
        ptr      <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end else if (bus.res_ready) begin
        state <= ST_EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomized self-checking bench for booth_mul_arbiter against a behavioural model.
module tb_booth_mul_arbiter;
  import booth_mul_arbiter_pkg::*;
  localparam int N = 4, IDW = 2, CNTW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CNTW-1:0] op_count;
  int              total = 0, bad = 0;

  // model state
  bit              m_valid;
  logic [7:0]      m_z;
  int              m_id, m_ptr;
  logic [CNTW-1:0] m_cnt;

  booth_mul_arbiter_if #(.NREQ(N), .IDW(IDW)) bus();

  booth_mul_arbiter #(.NREQ(N), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_prod(input logic [3:0] x, input logic [3:0] y);
    int a, b;
    a = x[3] ? int'(x) - 16 : int'(x);
    b = y[3] ? int'(y) - 16 : int'(y);
    return 8'(a * b);
  endfunction

  function automatic int exp_grant();
    if (!rst_n || (m_valid && !bus.res_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [30:0] exp_vec();
    int g = exp_grant();
    logic [3:0] rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
    return {m_valid, m_z, 2'(m_id), rdy, m_cnt};
  endfunction

  function automatic logic [30:0] got_vec();
    return {bus.res_valid, bus.res_z, bus.res_id, bus.req_ready, op_count};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_z = '0; m_id = 0; m_ptr = 0; m_cnt = '0;
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick(output int g);
    bit cons;
    logic [3:0] xg, yg;
    g = exp_grant();
    cons = m_valid && bus.res_ready && rst_n;
    xg = (g >= 0) ? bus.req_x[g] : 4'd0;
    yg = (g >= 0) ? bus.req_y[g] : 4'd0;
    @(posedge clk);
    if (cons) m_cnt++;
    if (g >= 0) begin
      m_valid = 1; m_z = ref_prod(xg, yg); m_id = g; m_ptr = (g + 1) % N;
    end else if (cons) m_valid = 0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; bus.req_valid = '0; bus.res_ready = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    bus.req_valid = '1; bus.res_ready = 1;
    for (int i = 0; i < N; i++) begin
      bus.req_x[i] = 4'($urandom); bus.req_y[i] = 4'($urandom);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.res_valid, bus.res_z, bus.res_id, op_count} !== 27'd0) begin
      bad++; $display("FAIL reset_state got=%h exp=0", {bus.res_valid, bus.res_z, bus.res_id, op_count});
    end
    total++;
    if (bus.req_ready !== 4'd0) begin
      bad++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
    end
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_single();
    int g;
    bus.res_ready = 1; bus.req_x[0] = 4'd3; bus.req_y[0] = 4'd5; bus.req_valid = 4'b0001;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++; $display("FAIL single_grant got=%b exp=0001", bus.req_ready);
    end
    tick(g);
    bus.req_valid = '0;
    @(negedge clk);
    total++;
    if ({bus.res_valid, bus.res_z, bus.res_id} !== {1'b1, 8'h0F, 2'd0}) begin
      bad++; $display("FAIL single_result got=%b/%h/%0d exp=1/0f/0", bus.res_valid, bus.res_z, bus.res_id);
    end
    tick(g);
    @(negedge clk);
    total++;
    if ({bus.res_valid, op_count} !== {1'b0, 16'd1}) begin
      bad++; $display("FAIL single_count got=%b/%0d exp=0/1", bus.res_valid, op_count);
    end
    total++;
    if (got_vec() !== exp_vec()) begin
      bad++; $display("FAIL single_model got=%h exp=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_corners();
    logic [3:0] xs [3] = '{4'h8, 4'h7, 4'h0};
    logic [3:0] ys [3] = '{4'h8, 4'hF, 4'h9};
    logic [7:0] zs [3] = '{8'h40, 8'hF9, 8'h00};
    int g;
    bus.res_ready = 1;
    for (int k = 0; k < 3; k++) begin
      bus.req_x[k+1] = xs[k]; bus.req_y[k+1] = ys[k];
      bus.req_valid = 4'(1 << (k + 1));
      tick(g);
      bus.req_valid = '0;
      @(negedge clk);
      total++;
      if (bus.res_z !== zs[k] || bus.res_id !== 2'(k + 1) || bus.res_valid !== 1'b1) begin
        bad++; $display("FAIL corner%0d got=%h/%0d exp=%h/%0d", k, bus.res_z, bus.res_id, zs[k], k + 1);
      end
    end
  endtask

  task automatic test_fairness();
    int g;
    do_reset();
    bus.res_ready = 1;
    for (int i = 0; i < N; i++) begin
      bus.req_x[i] = 4'($urandom); bus.req_y[i] = 4'($urandom);
    end
    bus.req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready !== 4'(1 << (k % 4))) begin
        bad++; $display("FAIL fair_order%0d got=%b exp=%b", k, bus.req_ready, 4'(1 << (k % 4)));
      end
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++; $display("FAIL fair_model%0d got=%h exp=%h", k, got_vec(), exp_vec());
      end
      tick(g);
      if (g >= 0) begin
        bus.req_x[g] = 4'($urandom); bus.req_y[g] = 4'($urandom);
      end
    end
    bus.req_valid = '0;
    tick(g);
    @(negedge clk);
    total++;
    if (op_count !== 16'd6) begin
      bad++; $display("FAIL fair_count got=%0d exp=6", op_count);
    end
  endtask

  task automatic test_backpressure();
    int g;
    bus.res_ready = 0;
    bus.req_x[1] = 4'hD; bus.req_y[1] = 4'h6;
    bus.req_valid = 4'b0010;
    tick(g);
    bus.req_valid = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({bus.res_valid, bus.res_z, bus.res_id, bus.req_ready} !== {1'b1, 8'hEE, 2'd1, 4'd0}) begin
        bad++; $display("FAIL stall%0d got=%b/%h/%0d/%b exp=1/ee/1/0000", k, bus.res_valid, bus.res_z, bus.res_id, bus.req_ready);
      end
      tick(g);
    end
    bus.res_ready = 1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0100) begin
      bad++; $display("FAIL release_grant got=%b exp=0100", bus.req_ready);
    end
    total++;
    if (got_vec() !== exp_vec()) begin
      bad++; $display("FAIL release_model got=%h exp=%h", got_vec(), exp_vec());
    end
    tick(g);
    bus.req_valid = '0;
    @(negedge clk);
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2) begin
      bad++; $display("FAIL release_result got=%b/%0d exp=1/2", bus.res_valid, bus.res_id);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    bus.res_ready = 0;
    bus.req_x[2] = 4'($urandom); bus.req_y[2] = 4'($urandom);
    bus.req_valid = 4'b0100;
    tick(g);
    bus.req_valid = '0;
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    total++;
    if ({bus.res_valid, op_count, bus.req_ready} !== 21'd0) begin
      bad++; $display("FAIL async_reset got=%b/%0d/%b exp=0/0/0000", bus.res_valid, op_count, bus.req_ready);
    end
    model_reset();
    bus.req_valid = 4'b1100; bus.res_ready = 1;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0100) begin
      bad++; $display("FAIL post_reset_grant got=%b exp=0100", bus.req_ready);
    end
    tick(g);
    bus.req_valid = '0;
    tick(g);
  endtask

  task automatic test_sweep();
    int g, next = 0, done = 0, cyc = 0, sz;
    while ((done < 256 || m_valid) && cyc < 4000) begin
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i] && next < 256 && $urandom_range(0, 1) == 1) begin
          bus.req_x[i] = 4'(next >> 4); bus.req_y[i] = 4'(next);
          bus.req_valid[i] = 1'b1;
          next++;
        end
      bus.res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++; $display("FAIL sweep cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
      end
      if (bus.res_valid) begin
        sz = int'($signed(bus.res_z));
        total++;
        if (sz < PROD_MIN || sz > PROD_MAX) begin
          bad++; $display("FAIL sweep_range cyc=%0d got=%0d exp=%0d..%0d", cyc, sz, PROD_MIN, PROD_MAX);
        end
      end
      tick(g);
      if (g >= 0) begin
        bus.req_valid[g] = 1'b0;
        done++;
      end
      cyc++;
    end
    total++;
    if (done != 256 || m_valid) begin
      bad++; $display("FAIL sweep_timeout got=%0d exp=256", done);
    end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_x = '0; bus.req_y = '0; bus.res_ready = 0;
    test_reset();
    test_single();
    test_corners();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
